// File: rtl/ascii_cmd_bridge.sv
// ascii_cmd_bridge: parses ASCII bus commands from a UART byte stream,
// performs the matching bus write or read, and streams the reply back.
module ascii_cmd_bridge #(
  parameter int AddrWidth   = 16,
  parameter int DataWidth   = 32,
  parameter int ReadLatency = 2,
  parameter int VersionLen  = 13,
  parameter logic [8*VersionLen-1:0] VersionString = "REF-FPGA-LITE"
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_valid_i,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic [AddrWidth-1:0] bus_address_o,
  output logic [DataWidth-1:0] bus_data_o,
  output logic                 bus_we_o,
  input  logic [DataWidth-1:0] bus_data_i,
  input  logic                 bus_busy_i,
  output logic                 overrun_o,
  output logic [3:0]           dbg_state_o
);

  // Tx handshake: a byte moves on every edge where tx_valid_o and tx_ready_i
  // are both high; while valid is high and ready low, tx_data_o is frozen and
  // valid stays high. Valid only falls right after a transfer (or on reset).

  typedef enum logic [3:0] {
    ST_MATCH, ST_ADDR, ST_DATA, ST_DISCARD, ST_BUS_WR, ST_BUS_WAIT,
    ST_BUS_RD, ST_CONV, ST_SEND_NUM, ST_SEND_VER, ST_SEND_NL
  } state_t;

  localparam logic [47:0]  CmdWr  = "wFPGA,";
  localparam logic [47:0]  CmdRd  = "rFPGA,";
  localparam logic [119:0] CmdVer = "readFPGAVersion";

  function automatic logic [7:0] str_char(input logic [119:0] s, input int len, input int idx);
    logic [119:0] t;
    t = s >> (8 * (len - 1 - idx));
    return t[7:0];
  endfunction

  function automatic logic [7:0] ver_char(input logic [7:0] i);
    logic [8*VersionLen-1:0] t;
    t = VersionString >> (8 * (VersionLen - 1 - int'(i)));
    return t[7:0];
  endfunction

  function automatic logic [31:0] pow10(input logic [3:0] i);
    case (i)
      4'd0:    return 32'd1000000000;
      4'd1:    return 32'd100000000;
      4'd2:    return 32'd10000000;
      4'd3:    return 32'd1000000;
      4'd4:    return 32'd100000;
      4'd5:    return 32'd10000;
      4'd6:    return 32'd1000;
      4'd7:    return 32'd100;
      4'd8:    return 32'd10;
      default: return 32'd1;
    endcase
  endfunction

  state_t              r_state;
  logic [3:0]          r_idx;
  logic [2:0]          r_cand;
  logic                r_is_wr;
  logic [31:0]         r_acc;
  logic                r_have;
  logic [AddrWidth-1:0] r_addr;
  logic [7:0]          r_lat;
  logic [31:0]         r_val;
  logic [3:0]          r_pidx;
  logic [3:0]          r_dig;
  logic [3:0]          r_ndig;
  logic                r_started;
  logic [3:0]          r_buf [10];
  logic [7:0]          r_sidx;

  logic       w_is_digit;
  logic       w_cr;
  logic       w_nl;
  logic       w_comma;
  logic [2:0] w_cand_nxt;
  logic [31:0] w_pow;
  logic [7:0] w_sidx_nx;
  logic [7:0] w_ver_cur;
  logic [7:0] w_ver_nxt;
  logic       w_busy_state;

  assign w_is_digit = (rx_data_i >= 8'h30) && (rx_data_i <= 8'h39);
  assign w_cr       = (rx_data_i == 8'h0D);
  assign w_nl       = (rx_data_i == 8'h0A);
  assign w_comma    = (rx_data_i == 8'h2C);
  assign w_cand_nxt[0] = r_cand[0] && (r_idx < 4'd6) &&
                         (rx_data_i == str_char({72'd0, CmdWr}, 6, int'(r_idx)));
  assign w_cand_nxt[1] = r_cand[1] && (r_idx < 4'd6) &&
                         (rx_data_i == str_char({72'd0, CmdRd}, 6, int'(r_idx)));
  assign w_cand_nxt[2] = r_cand[2] && (r_idx < 4'd15) &&
                         (rx_data_i == str_char(CmdVer, 15, int'(r_idx)));
  assign w_pow      = pow10(r_pidx);
  assign w_sidx_nx  = r_sidx + 8'd1;
  assign w_ver_cur  = ver_char(r_sidx);
  assign w_ver_nxt  = ver_char(w_sidx_nx);
  assign w_busy_state = !((r_state == ST_MATCH) || (r_state == ST_ADDR) ||
                          (r_state == ST_DATA) || (r_state == ST_DISCARD));
  assign dbg_state_o = r_state;

  // Command FSM: parse, bus access, decimal conversion and reply streaming.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state       <= ST_MATCH;
      r_idx         <= '0;
      r_cand        <= 3'b111;
      r_is_wr       <= 1'b0;
      r_acc         <= '0;
      r_have        <= 1'b0;
      r_addr        <= '0;
      r_lat         <= '0;
      r_val         <= '0;
      r_pidx        <= '0;
      r_dig         <= '0;
      r_ndig        <= '0;
      r_started     <= 1'b0;
      r_sidx        <= '0;
      for (int i = 0; i < 10; i++) r_buf[i] <= '0;
      tx_data_o     <= '0;
      tx_valid_o    <= 1'b0;
      bus_address_o <= '0;
      bus_data_o    <= '0;
      bus_we_o      <= 1'b0;
      overrun_o     <= 1'b0;
    end else begin
      bus_we_o <= 1'b0;
      if (rx_valid_i && w_busy_state) overrun_o <= 1'b1;
      case (r_state)
        ST_MATCH: if (rx_valid_i && !w_cr) begin
          if (w_nl) begin
            r_idx  <= '0;
            r_cand <= 3'b111;
            if ((r_idx == 4'd15) && r_cand[2]) begin
              r_sidx  <= '0;
              r_state <= ST_SEND_VER;
            end
          end else if (w_cand_nxt == 3'b000) begin
            r_idx   <= '0;
            r_cand  <= 3'b111;
            r_state <= ST_DISCARD;
          end else if ((r_idx == 4'd5) && (w_cand_nxt[0] || w_cand_nxt[1])) begin
            r_idx   <= '0;
            r_cand  <= 3'b111;
            r_is_wr <= w_cand_nxt[0];
            r_acc   <= '0;
            r_have  <= 1'b0;
            r_state <= ST_ADDR;
          end else begin
            r_idx  <= r_idx + 4'd1;
            r_cand <= w_cand_nxt;
          end
        end
        ST_ADDR, ST_DATA: if (rx_valid_i && !w_cr) begin
          if (w_is_digit) begin
            r_acc  <= r_acc * 32'd10 + {28'd0, rx_data_i[3:0]};
            r_have <= 1'b1;
          end else if (w_comma && r_have && (r_state == ST_ADDR) && r_is_wr) begin
            r_addr  <= r_acc[AddrWidth-1:0];
            r_acc   <= '0;
            r_have  <= 1'b0;
            r_state <= ST_DATA;
          end else if (w_nl && r_have && (r_state == ST_ADDR) && !r_is_wr) begin
            bus_address_o <= r_acc[AddrWidth-1:0];
            r_lat         <= '0;
            r_state       <= ST_BUS_RD;
          end else if (w_nl && r_have && (r_state == ST_DATA)) begin
            bus_address_o <= r_addr;
            bus_data_o    <= r_acc;
            r_state       <= ST_BUS_WR;
          end else if (w_nl) begin
            r_state <= ST_MATCH;
          end else begin
            r_state <= ST_DISCARD;
          end
        end
        ST_DISCARD: if (rx_valid_i && w_nl) r_state <= ST_MATCH;
        ST_BUS_WR: if (!bus_busy_i) begin
          bus_we_o <= 1'b1;
          r_state  <= ST_BUS_WAIT;
        end
        ST_BUS_WAIT: if (!bus_busy_i) r_state <= ST_MATCH;
        ST_BUS_RD: begin
          if ((int'(r_lat) >= ReadLatency) && !bus_busy_i) begin
            r_val     <= bus_data_i;
            r_pidx    <= '0;
            r_dig     <= '0;
            r_ndig    <= '0;
            r_started <= 1'b0;
            r_state   <= ST_CONV;
          end else if (int'(r_lat) < ReadLatency) begin
            r_lat <= r_lat + 8'd1;
          end
        end
        ST_CONV: begin
          if (r_val >= w_pow) begin
            r_val <= r_val - w_pow;
            r_dig <= r_dig + 4'd1;
          end else begin
            if ((r_dig != 4'd0) || r_started || (r_pidx == 4'd9)) begin
              r_buf[r_ndig] <= r_dig;
              r_ndig        <= r_ndig + 4'd1;
              r_started     <= 1'b1;
            end
            r_dig <= '0;
            if (r_pidx == 4'd9) begin
              r_sidx  <= '0;
              r_state <= ST_SEND_NUM;
            end else begin
              r_pidx <= r_pidx + 4'd1;
            end
          end
        end
        ST_SEND_NUM: begin
          if (!tx_valid_o) begin
            tx_valid_o <= 1'b1;
            tx_data_o  <= {4'h3, r_buf[r_sidx[3:0]]};
          end else if (tx_ready_i) begin
            if (w_sidx_nx < {4'd0, r_ndig}) begin
              r_sidx    <= w_sidx_nx;
              tx_data_o <= {4'h3, r_buf[w_sidx_nx[3:0]]};
            end else begin
              tx_valid_o <= 1'b0;
              r_state    <= ST_SEND_NL;
            end
          end
        end
        ST_SEND_VER: begin
          if (!tx_valid_o) begin
            tx_valid_o <= 1'b1;
            tx_data_o  <= w_ver_cur;
          end else if (tx_ready_i) begin
            if (int'(w_sidx_nx) < VersionLen) begin
              r_sidx    <= w_sidx_nx;
              tx_data_o <= w_ver_nxt;
            end else begin
              tx_valid_o <= 1'b0;
              r_state    <= ST_SEND_NL;
            end
          end
        end
        ST_SEND_NL: begin
          if (!tx_valid_o) begin
            tx_valid_o <= 1'b1;
            tx_data_o  <= 8'h0A;
          end else if (tx_ready_i) begin
            tx_valid_o <= 1'b0;
            r_state    <= ST_MATCH;
          end
        end
        default: r_state <= ST_MATCH;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_cmd_bridge.sv
// tb_ascii_cmd_bridge: directed and randomized command lines checked against
// a line-level reference model of the command protocol.
module tb_ascii_cmd_bridge;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic [15:0] bus_address_o;
  logic [31:0] bus_data_o;
  logic        bus_we_o;
  logic [31:0] bus_data_i = 32'h0;
  logic        bus_busy_i = 1'b0;
  logic        overrun_o;
  logic [3:0]  dbg_state_o;

  ascii_cmd_bridge dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .bus_address_o(bus_address_o), .bus_data_o(bus_data_o), .bus_we_o(bus_we_o),
    .bus_data_i(bus_data_i), .bus_busy_i(bus_busy_i),
    .overrun_o(overrun_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0]  exp_q[$];
  logic [47:0] exp_wr_q[$];
  logic [7:0]  cur_line[$];
  int last_rx_cyc = 0, we_cyc = 0, we_count = 0, tx_count = 0;
  int busy_mode = 0, ready_mode = 1, rdy_cnt = 0;
  logic [15:0] last_addr = 16'h0;
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0] prev_d = 8'h0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- busy / ready drivers ----------------
  always @(posedge clk_i) begin
    #2;
    case (busy_mode)
      0: bus_busy_i = 1'b0;
      1: bus_busy_i = 1'b1;
      default: bus_busy_i = ($urandom_range(0, 3) == 0);
    endcase
    case (ready_mode)
      0: tx_ready_i = 1'b0;
      1: tx_ready_i = 1'b1;
      2: begin rdy_cnt++; tx_ready_i = ((rdy_cnt % 51) == 50); end
      default: tx_ready_i = ($urandom_range(0, 1) == 1);
    endcase
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_i) begin
    if (!reset_n_i) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        check_eq("tx_hold_valid", tx_valid_o, 1);
        check_eq("tx_hold_data", tx_data_o, prev_d);
      end
      if (tx_valid_o && tx_ready_i) begin
        tx_count++;
        check_eq("tx_expected_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check_eq("tx_byte", tx_data_o, exp_q.pop_front());
      end
      if (bus_we_o) begin
        we_count++;
        we_cyc = cyc;
        check_eq("we_expected_pending", exp_wr_q.size() > 0, 1);
        if (exp_wr_q.size() > 0) check_eq("bus_write", {bus_address_o, bus_data_o}, exp_wr_q.pop_front());
      end
      prev_v = tx_valid_o;
      prev_r = tx_ready_i;
      prev_d = tx_data_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_i); #1;
    rx_data_i = b;
    rx_valid_i = 1'b1;
    last_rx_cyc = cyc;
    @(posedge clk_i); #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic set_line(input string s);
    cur_line.delete();
    for (int i = 0; i < s.len(); i++) cur_line.push_back(s[i]);
    cur_line.push_back(8'h0A);
  endtask

  task automatic send_line();
    for (int i = 0; i < cur_line.size(); i++) send_byte(cur_line[i]);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    int saved;
    while ((exp_q.size() != 0 || exp_wr_q.size() != 0) && n < budget) begin
      @(posedge clk_i); n++;
    end
    check_eq("drain", exp_q.size() + exp_wr_q.size(), 0);
    saved = busy_mode;
    busy_mode = 0;
    repeat (4) @(posedge clk_i);
    busy_mode = saved;
    #1;
  endtask

  function automatic string rand_digits();
    string s = "";
    int n = $urandom_range(1, 11);
    for (int i = 0; i < n; i++) s = {s, $sformatf("%0d", $urandom_range(0, 9))};
    return s;
  endfunction

  // ---------------- reference model ----------------
  // Interprets a whole line by the protocol rules; returns 0 none, 1 write,
  // 2 read, 3 version, and pushes the expected bus write / reply bytes.
  task automatic model_line(input logic [31:0] rd_val, output int kind, output logic [15:0] addr);
    logic [7:0] t[$];
    string ver = "readFPGAVersion";
    string wpf = "wFPGA,";
    string rpf = "rFPGA,";
    string vstr = "REF-FPGA-LITE";
    string num;
    logic is_w, is_r, bad, m;
    int ncomma, n1, n2;
    logic [63:0] v1, v2;
    kind = 0; addr = 16'h0;
    for (int i = 0; i < cur_line.size() - 1; i++) if (cur_line[i] != 8'h0D) t.push_back(cur_line[i]);
    if (t.size() == 15) begin
      m = 1'b1;
      for (int i = 0; i < 15; i++) if (t[i] != ver[i]) m = 1'b0;
      if (m) kind = 3;
    end else if (t.size() > 6) begin
      is_w = 1'b1; is_r = 1'b1;
      for (int i = 0; i < 6; i++) begin
        if (t[i] != wpf[i]) is_w = 1'b0;
        if (t[i] != rpf[i]) is_r = 1'b0;
      end
      ncomma = 0; n1 = 0; n2 = 0; bad = 1'b0; v1 = 0; v2 = 0;
      for (int i = 6; i < t.size(); i++) begin
        if (t[i] == 8'h2C) ncomma++;
        else if (t[i] >= 8'h30 && t[i] <= 8'h39) begin
          if (ncomma == 0) begin n1++; v1 = (v1 * 10 + 64'(t[i] - 8'h30)) % 64'h1_0000_0000; end
          else begin n2++; v2 = (v2 * 10 + 64'(t[i] - 8'h30)) % 64'h1_0000_0000; end
        end else bad = 1'b1;
      end
      if (is_w && !bad && ncomma == 1 && n1 > 0 && n2 > 0) kind = 1;
      if (is_r && !bad && ncomma == 0 && n1 > 0) kind = 2;
      addr = v1[15:0];
      if (kind == 1) exp_wr_q.push_back({v1[15:0], v2[31:0]});
    end
    if (kind == 2) begin
      num = $sformatf("%0d", rd_val);
      for (int i = 0; i < num.len(); i++) exp_q.push_back(num[i]);
      exp_q.push_back(8'h0A);
    end
    if (kind == 3) begin
      for (int i = 0; i < vstr.len(); i++) exp_q.push_back(vstr[i]);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic run_line(input logic [31:0] rd_val, input string tag);
    int kind;
    logic [15:0] a;
    model_line(rd_val, kind, a);
    bus_data_i = rd_val;
    send_line();
    wait_drain(3000);
    if (kind == 1 || kind == 2) last_addr = a;
    check_eq({tag, "_addr"}, bus_address_o, last_addr);
  endtask

  // ---------------- main sequence ----------------
  string bad_tab[5] = '{"wFPGA,12x,5", "rFPGA,,", "readFPGAVersio", "rFPGA,7,", "wFPGA,5"};
  int we0, tx0, busy_fall, n;
  string s;

  initial begin
    // reset
    reset_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_eq("rst_tx_valid", tx_valid_o, 0);
    check_eq("rst_tx_data", tx_data_o, 0);
    check_eq("rst_addr", bus_address_o, 0);
    check_eq("rst_data", bus_data_o, 0);
    check_eq("rst_we", bus_we_o, 0);
    check_eq("rst_overrun", overrun_o, 0);
    @(posedge clk_i); #1 reset_n_i = 1'b1;
    ready_mode = 1; busy_mode = 0;

    // write
    we0 = we_count; tx0 = tx_count;
    set_line("wFPGA,36868,305419896");
    run_line(32'h0, "write");
    check_eq("write_latency", we_cyc - last_rx_cyc, 2);
    check_eq("write_pulses", we_count - we0, 1);
    check_eq("write_no_tx", tx_count - tx0, 0);

    // reads
    set_line("rFPGA,36864"); run_line(32'hFFFF_FFFF, "read_max");
    set_line("rFPGA,36864"); run_line(32'h0, "read_zero");
    set_line("rFPGA,36864"); run_line(32'd1000, "read_1000");

    // version with slow transmitter
    ready_mode = 2;
    set_line("readFPGAVersion"); run_line(32'h0, "version");
    ready_mode = 1;

    // malformed lines
    we0 = we_count; tx0 = tx_count;
    set_line("wFPGA,12x,5"); run_line(32'h0, "bad_wr");
    set_line("rFPGA,,"); run_line(32'h0, "bad_rd");
    set_line("readFPGAVersio"); run_line(32'h0, "bad_ver");
    check_eq("bad_no_we", we_count - we0, 0);
    check_eq("bad_no_tx", tx_count - tx0, 0);
    set_line("rFPGA,42"); run_line(32'd987654321, "after_bad");

    // stalled write
    we0 = we_count;
    busy_mode = 1;
    set_line("wFPGA,4660,48879");
    begin int kind; logic [15:0] a; model_line(32'h0, kind, a); last_addr = a; end
    send_line();
    repeat (20) @(posedge clk_i);
    #1 check_eq("stall_no_we", we_count - we0, 0);
    busy_mode = 0; busy_fall = cyc;
    wait_drain(500);
    check_eq("stall_we_once", we_count - we0, 1);
    check_eq("stall_we_after_busy", we_cyc > busy_fall, 1);

    // stalled read
    tx0 = tx_count;
    busy_mode = 1;
    set_line("rFPGA,4660");
    begin int kind; logic [15:0] a; model_line(32'hCAFE_F00D, kind, a); last_addr = a; end
    bus_data_i = 32'hCAFE_F00D;
    send_line();
    repeat (20) @(posedge clk_i);
    #1 check_eq("stall_no_tx", tx_count - tx0, 0);
    busy_mode = 0;
    wait_drain(500);
    check_eq("stall_rd_addr", bus_address_o, 16'h1234);

    // randomized lines
    ready_mode = 3;
    for (int k = 0; k < 40; k++) begin
      logic [31:0] rv;
      case ($urandom_range(0, 5))
        0: s = {"wFPGA,", rand_digits(), ",", rand_digits()};
        1: s = {"rFPGA,", rand_digits()};
        2: s = "readFPGAVersion";
        3: s = bad_tab[$urandom_range(0, 4)];
        4: s = {"wFPGA,", rand_digits(), ",", rand_digits()};
        default: s = "";
      endcase
      set_line(s);
      if (s.len() > 0 && $urandom_range(0, 2) == 0)
        cur_line[$urandom_range(0, cur_line.size() - 2)] = ($urandom_range(0, 1) == 0) ? 8'h78 : 8'h2C;
      if ($urandom_range(0, 3) == 0) cur_line.insert($urandom_range(0, cur_line.size() - 1), 8'h0D);
      case ($urandom_range(0, 2))
        0: rv = $urandom;
        1: rv = $urandom_range(0, 20);
        default: rv = 32'hFFFF_FFFF;
      endcase
      busy_mode = 2;
      run_line(rv, "rand");
      busy_mode = 0;
    end
    check_eq("rand_no_overrun", overrun_o, 0);

    // overrun then reset mid-reply
    ready_mode = 0;
    set_line("rFPGA,1");
    begin int kind; logic [15:0] a; model_line(32'd123456, kind, a); end
    bus_data_i = 32'd123456;
    send_line();
    n = 0;
    @(negedge clk_i);
    while (!tx_valid_o && n < 500) begin @(negedge clk_i); n++; end
    check_eq("reply_started", tx_valid_o, 1);
    send_byte(8'h5A);
    @(negedge clk_i);
    check_eq("overrun_set", overrun_o, 1);
    @(posedge clk_i); #1 reset_n_i = 1'b0;
    #1;
    check_eq("arst_tx_valid", tx_valid_o, 0);
    check_eq("arst_tx_data", tx_data_o, 0);
    check_eq("arst_we", bus_we_o, 0);
    check_eq("arst_addr", bus_address_o, 0);
    check_eq("arst_data", bus_data_o, 0);
    check_eq("arst_overrun", overrun_o, 0);
    exp_q.delete();
    exp_wr_q.delete();
    last_addr = 16'h0;
    repeat (3) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    ready_mode = 1;
    set_line("rFPGA,65537"); run_line(32'd4000000000, "post_reset");
    check_eq("post_reset_overrun", overrun_o, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
